// File: rtl/s3g_uart_rx.sv
// 8N1 asynchronous serial receiver, LSB first, idle-high line.
// Feeds the S3G packet parser with a byte plus a one-cycle rx_done strobe.
module s3g_uart_rx #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_done,
  output logic       rx_frame_error,
  output logic       rx_busy
);

  localparam int HALF  = CLKS_PER_BIT / 2;
  localparam int TMR_W = $clog2(CLKS_PER_BIT);
  localparam logic [TMR_W-1:0] HALF_LAST = TMR_W'(HALF - 1);
  localparam logic [TMR_W-1:0] BIT_LAST  = TMR_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    WAIT_IDLE = 3'd0,
    IDLE      = 3'd1,
    START     = 3'd2,
    DATA      = 3'd3,
    STOP      = 3'd4
  } state_t;

  state_t state, state_nxt;

  logic             rx_meta, rx_s;
  logic             vld_p0, vld_p1;
  logic [TMR_W-1:0] timer;
  logic [2:0]       bit_idx;
  logic [7:0]       shift;

  logic half_tick, bit_tick, last_bit;
  logic tmr_clr, idx_clr, shift_en, done_set, err_set;

  // Synchronizer stage: rx_s is reset to the idle level, but vld_p1 marks when
  // it holds a genuine line sample so a low line at reset cannot look idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      vld_p0  <= 1'b0;
      vld_p1  <= 1'b0;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
      vld_p0  <= 1'b1;
      vld_p1  <= vld_p0;
    end
  end

  assign half_tick = (timer == HALF_LAST);
  assign bit_tick  = (timer == BIT_LAST);
  assign last_bit  = (bit_idx == 3'd7);

  always_ff @(posedge clk) begin
    if (rst) state <= WAIT_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      WAIT_IDLE: if (rx_s && vld_p1) state_nxt = IDLE;
      IDLE:      if (!rx_s)          state_nxt = START;
      START:     if (half_tick)      state_nxt = rx_s ? IDLE : DATA;
      DATA:      if (bit_tick && last_bit) state_nxt = STOP;
      STOP:      if (bit_tick)       state_nxt = rx_s ? IDLE : WAIT_IDLE;
      default:                       state_nxt = WAIT_IDLE;
    endcase
  end

  // Timer free-runs only inside a frame and restarts at every sample point.
  always_comb begin
    tmr_clr  = 1'b1;
    idx_clr  = 1'b0;
    shift_en = 1'b0;
    done_set = 1'b0;
    err_set  = 1'b0;
    rx_busy  = 1'b0;
    case (state)
      START: begin
        rx_busy = 1'b1;
        tmr_clr = half_tick;
        idx_clr = half_tick;
      end
      DATA: begin
        rx_busy  = 1'b1;
        tmr_clr  = bit_tick;
        shift_en = bit_tick;
      end
      STOP: begin
        rx_busy  = 1'b1;
        tmr_clr  = bit_tick;
        done_set = bit_tick && rx_s;
        err_set  = bit_tick && !rx_s;
      end
      default: begin
        tmr_clr = 1'b1;
      end
    endcase
  end

  // Sample stage: shift in from the MSB side so bit 0 lands in rx_data[0].
  always_ff @(posedge clk) begin
    if (rst) begin
      timer          <= '0;
      bit_idx        <= 3'd0;
      shift          <= 8'd0;
      rx_data        <= 8'd0;
      rx_done        <= 1'b0;
      rx_frame_error <= 1'b0;
    end else begin
      timer <= tmr_clr ? '0 : timer + TMR_W'(1);
      if (idx_clr)       bit_idx <= 3'd0;
      else if (shift_en) bit_idx <= bit_idx + 3'd1;
      if (shift_en)      shift   <= {rx_s, shift[7:1]};
      if (done_set)      rx_data <= shift;
      rx_done        <= done_set;
      rx_frame_error <= err_set;
    end
  end

endmodule

// File: tb/tb_s3g_uart_rx.sv
// Bench for s3g_uart_rx: frame-level reference model, vector table,
// randomized frames and hand-written corner sequences.
module tb_s3g_uart_rx;

  localparam int C = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx  = 1'b1;
  logic [7:0] rx_data;
  logic       rx_done, rx_frame_error, rx_busy;

  s3g_uart_rx #(.CLKS_PER_BIT(C)) dut (
    .clk(clk), .rst(rst), .rx(rx),
    .rx_data(rx_data), .rx_done(rx_done),
    .rx_frame_error(rx_frame_error), .rx_busy(rx_busy)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic       err;
    logic [7:0] data;
  } exp_t;
  exp_t exp_q[$];

  typedef struct {
    logic [7:0] data;
    logic       stop;
    int         gap;
    logic       exp_done;
    logic       exp_err;
    logic [7:0] exp_data;
  } vec_t;

  logic       mon_en    = 1'b0;
  logic       prev_done = 1'b0;
  logic       prev_err  = 1'b0;
  logic       prev_rst  = 1'b1;
  logic [7:0] prev_data = 8'd0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  // Frame-level model: a good stop bit delivers the byte, a low one an error.
  task automatic expect_frame(input logic [7:0] d, input logic stop);
    exp_t e;
    e.err  = !stop;
    e.data = d;
    exp_q.push_back(e);
  endtask

  function automatic logic [7:0] crc8(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    logic [7:0] crc;
    logic [7:0] bytes [3];
    crc = 8'h00;
    bytes[0] = a; bytes[1] = b; bytes[2] = c;
    for (int k = 0; k < 3; k++) begin
      crc = crc ^ bytes[k];
      for (int j = 0; j < 8; j++)
        crc = crc[7] ? ((crc << 1) ^ 8'h07) : (crc << 1);
    end
    return crc;
  endfunction

  // All drivers start just after a rising edge and leave just after one.
  task automatic drive_bits(input logic v, input int nbits);
    rx = v;
    if (nbits > 0) begin
      repeat (nbits * C) @(posedge clk);
      #1;
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop);
    drive_bits(1'b0, 1);
    for (int i = 0; i < 8; i++) drive_bits(d[i], 1);
    drive_bits(stop, 1);
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (rx_done || rx_frame_error) begin
        chk("strobe_exclusive", {31'd0, rx_done & rx_frame_error}, 32'd0);
        chk("strobe_one_cycle", {31'd0, (prev_done & rx_done) | (prev_err & rx_frame_error)}, 32'd0);
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_strobe: done=%0b err=%0b data=%02h, required no strobe",
                   rx_done, rx_frame_error, rx_data);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("strobe_kind_err", {31'd0, rx_frame_error}, {31'd0, e.err});
          if (!e.err) chk("rx_data", {24'd0, rx_data}, {24'd0, e.data});
        end
      end
      if (!prev_rst && !rx_done) chk("rx_data_hold", {24'd0, rx_data}, {24'd0, prev_data});
    end
    prev_done = rx_done;
    prev_err  = rx_frame_error;
    prev_data = rx_data;
    prev_rst  = rst;
  end

  initial begin
    vec_t vecs [6];
    logic busy_seen;
    logic prev_bad;

    vecs[0] = '{data: 8'h00, stop: 1'b1, gap: 0, exp_done: 1'b1, exp_err: 1'b0, exp_data: 8'h00};
    vecs[1] = '{data: 8'hFF, stop: 1'b1, gap: 0, exp_done: 1'b1, exp_err: 1'b0, exp_data: 8'hFF};
    vecs[2] = '{data: 8'hA5, stop: 1'b1, gap: 1, exp_done: 1'b1, exp_err: 1'b0, exp_data: 8'hA5};
    vecs[3] = '{data: 8'h3C, stop: 1'b0, gap: 1, exp_done: 1'b0, exp_err: 1'b1, exp_data: 8'h00};
    vecs[4] = '{data: 8'h80, stop: 1'b1, gap: 0, exp_done: 1'b1, exp_err: 1'b0, exp_data: 8'h80};
    vecs[5] = '{data: 8'h01, stop: 1'b1, gap: 2, exp_done: 1'b1, exp_err: 1'b0, exp_data: 8'h01};

    // Reset state
    @(posedge clk);
    @(negedge clk);
    chk("reset_rx_data", {24'd0, rx_data}, 32'd0);
    chk("reset_rx_done", {31'd0, rx_done}, 32'd0);
    chk("reset_rx_frame_error", {31'd0, rx_frame_error}, 32'd0);
    chk("reset_rx_busy", {31'd0, rx_busy}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    mon_en = 1'b1;
    drive_bits(1'b1, 5);

    // 1: single byte with exact strobe and busy timing
    expect_frame(8'hD5, 1'b1);
    fork
      send_frame(8'hD5, 1'b1);
      begin
        int n;
        logic seen;
        n = 0;
        seen = 1'b0;
        while (n < 300 && !seen) begin
          @(posedge clk);
          n++;
          @(negedge clk);
          if (n == 2)   chk("t1_busy_before_t0", {31'd0, rx_busy}, 32'd0);
          if (n == 3)   chk("t1_busy_at_t0", {31'd0, rx_busy}, 32'd1);
          if (n == 154) chk("t1_busy_before_stop", {31'd0, rx_busy}, 32'd1);
          if (n == 155) chk("t1_busy_after_stop", {31'd0, rx_busy}, 32'd0);
          if (rx_done) seen = 1'b1;
        end
        chk("t1_done_cycle", n, 32'd155);
      end
    join
    drive_bits(1'b1, 2);
    chk("t1_drained", exp_q.size(), 32'd0);

    // 2: back-to-back frames, zero idle gap
    begin
      logic [7:0] seq [6];
      seq[0] = 8'hD5; seq[1] = 8'h03; seq[2] = 8'h01;
      seq[3] = 8'h02; seq[4] = 8'h03; seq[5] = crc8(8'h01, 8'h02, 8'h03);
      for (int i = 0; i < 6; i++) begin
        expect_frame(seq[i], 1'b1);
        send_frame(seq[i], 1'b1);
      end
    end
    drive_bits(1'b1, 2);
    chk("t2_drained", exp_q.size(), 32'd0);

    // Vector table
    for (int i = 0; i < 6; i++) begin
      if (vecs[i].exp_done) expect_frame(vecs[i].exp_data, 1'b1);
      if (vecs[i].exp_err)  expect_frame(vecs[i].data, 1'b0);
      send_frame(vecs[i].data, vecs[i].stop);
      drive_bits(1'b1, vecs[i].gap);
      chk($sformatf("vec%0d_drained", i), exp_q.size(), 32'd0);
    end
    drive_bits(1'b1, 1);

    // 3: 4-clock glitch must not start a frame
    busy_seen = 1'b0;
    rx = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rx = 1'b1;
    for (int i = 0; i < 2 * C; i++) begin
      @(negedge clk);
      busy_seen |= rx_busy;
    end
    chk("t3_busy_pulsed", {31'd0, busy_seen}, 32'd1);
    chk("t3_busy_back_low", {31'd0, rx_busy}, 32'd0);
    @(posedge clk); #1;
    expect_frame(8'h7E, 1'b1);
    send_frame(8'h7E, 1'b1);
    drive_bits(1'b1, 2);
    chk("t3_drained", exp_q.size(), 32'd0);

    // 4: framing error followed by a long break
    expect_frame(8'hD5, 1'b1);
    send_frame(8'hD5, 1'b1);
    drive_bits(1'b1, 1);
    expect_frame(8'h55, 1'b0);
    send_frame(8'h55, 1'b0);
    drive_bits(1'b0, 40);
    drive_bits(1'b1, 2);
    chk("t4_data_held", {24'd0, rx_data}, 32'hD5);
    chk("t4_error_seen", exp_q.size(), 32'd0);
    expect_frame(8'hA3, 1'b1);
    send_frame(8'hA3, 1'b1);
    drive_bits(1'b1, 2);
    chk("t4_drained", exp_q.size(), 32'd0);
    chk("t4_final_data", {24'd0, rx_data}, 32'hA3);

    // 5: reset pulse in the middle of bit 3 of 0x5A
    drive_bits(1'b0, 1);
    for (int i = 0; i < 3; i++) drive_bits(logic'(8'h5A >> i), 1);
    rx = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("t5_rst_rx_data", {24'd0, rx_data}, 32'd0);
    chk("t5_rst_rx_done", {31'd0, rx_done}, 32'd0);
    chk("t5_rst_rx_frame_error", {31'd0, rx_frame_error}, 32'd0);
    chk("t5_rst_rx_busy", {31'd0, rx_busy}, 32'd0);
    @(posedge clk); #1;
    drive_bits(1'b1, 2);
    expect_frame(8'h3C, 1'b1);
    send_frame(8'h3C, 1'b1);
    drive_bits(1'b1, 2);
    chk("t5_drained", exp_q.size(), 32'd0);

    // 6: line held low across reset release
    rx = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    drive_bits(1'b0, 20);
    drive_bits(1'b1, 1);
    chk("t6_no_strobe_in_break", exp_q.size(), 32'd0);
    expect_frame(8'h81, 1'b1);
    send_frame(8'h81, 1'b1);
    drive_bits(1'b1, 2);
    chk("t6_drained", exp_q.size(), 32'd0);
    chk("t6_data", {24'd0, rx_data}, 32'h81);

    // Randomized frames against the frame-level model
    prev_bad = 1'b0;
    for (int i = 0; i < 30; i++) begin
      logic [7:0] d;
      logic       stop;
      int         gap;
      d    = 8'($urandom);
      stop = ($urandom_range(0, 7) != 0);
      gap  = $urandom_range(0, 2);
      if (prev_bad && gap == 0) gap = 1;
      drive_bits(1'b1, gap);
      expect_frame(d, stop);
      send_frame(d, stop);
      prev_bad = !stop;
    end
    drive_bits(1'b1, 2);
    chk("rand_drained", exp_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
